// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths, the {tag,value} packet layout, and a pointer-width helper.
package cdb_arbiter_pkg;

   localparam int unsigned CDB_DATA_WIDTH = 32;
   localparam int unsigned CDB_TAG_WIDTH  = 3;

   // Broadcast packet layout, shared with the reservation stations and the ROB.
   typedef struct packed {
      logic [CDB_TAG_WIDTH-1:0]  tag;
      logic [CDB_DATA_WIDTH-1:0] value;
   } cdb_pkt_t;

   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result queue: DEPTH entries of {tag,value}, with a synchronous clear used by flush.
module cdb_arbiter_result_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = CDB_TAG_WIDTH + CDB_DATA_WIDTH,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: per-FU result queues, round-robin grant, one registered broadcast per cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CDB_DATA_WIDTH,
   parameter int unsigned TAG_WIDTH  = CDB_TAG_WIDTH,
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DEPTH      = 2,
   localparam int unsigned SRC_W     = $clog2(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [NUM_SRC-1:0]            src_valid,
   output logic [NUM_SRC-1:0]            src_ready,
   input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_value,
   output logic                          cdb_valid,
   output logic [TAG_WIDTH-1:0]          cdb_tag,
   output logic [DATA_WIDTH-1:0]         cdb_value,
   output logic [SRC_W-1:0]              cdb_src
);

   localparam int unsigned PKT_W = TAG_WIDTH + DATA_WIDTH;

   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [PKT_W-1:0]   head [NUM_SRC];
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   grant;
   logic [SRC_W-1:0]   next_rr;
   logic [SRC_W-1:0]   idx;
   logic               grant_valid;

   // Handshakes in a flush cycle are discarded, so pushes are masked here.
   assign src_ready = ~full;
   assign push      = src_valid & ~full & {NUM_SRC{~flush}};

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      cdb_arbiter_result_fifo #(
         .WIDTH (PKT_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .clear     (flush),
         .push      (push[i]),
         .push_data ({src_tag[i*TAG_WIDTH +: TAG_WIDTH], src_value[i*DATA_WIDTH +: DATA_WIDTH]}),
         .pop       (pop[i]),
         .head_data (head[i]),
         .empty     (empty[i]),
         .full      (full[i])
      );
   end

   // First non-empty queue scanning upward from rr_ptr, wrapping at NUM_SRC.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      idx         = '0;
      pop         = '0;
      for (int unsigned o = 0; o < NUM_SRC; o++) begin
         idx = SRC_W'((32'(rr_ptr) + o) % NUM_SRC);
         if (!grant_valid && !empty[idx]) begin
            grant_valid = 1'b1;
            grant       = idx;
         end
      end
      if (grant_valid && !flush) pop[grant] = 1'b1;
      next_rr = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
      end else if (grant_valid) begin
         cdb_valid              <= 1'b1;
         {cdb_tag, cdb_value}   <= head[grant];
         cdb_src                <= grant;
         rr_ptr                 <= next_rr;
      end else begin
         cdb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 3;
   localparam int D  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    src_valid;
   logic [N-1:0]    src_ready;
   logic [N*TW-1:0] src_tag;
   logic [N*DW-1:0] src_value;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_value;
   logic [1:0]      cdb_src;

   typedef struct { logic [TW-1:0] tag; logic [DW-1:0] value; } pkt_t;
   typedef struct { logic [TW-1:0] tag; logic [DW-1:0] value; int src; } bc_t;

   pkt_t          mq [N][$];
   bc_t           exp_q [$];
   int            rr;
   bit            m_valid;
   logic [TW-1:0] m_tag;
   logic [DW-1:0] m_value;
   int            m_src;
   int            errors = 0;
   int            checks = 0;
   bit            mon_en = 1'b0;

   cdb_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_SRC(N), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_tag   (src_tag),
      .src_value (src_value),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: per-source queues, rotating priority, applied at each rising edge.
   always @(posedge clk) begin
      int   g;
      bit   rdy [N];
      pkt_t p;
      if (rst) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         exp_q.delete();
         rr = 0; m_valid = 0; m_tag = '0; m_value = '0; m_src = 0;
      end else begin
         for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
         g = -1;
         for (int o = 0; o < N; o++)
            if (g < 0 && mq[(rr + o) % N].size() != 0) g = (rr + o) % N;
         if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 0;
         end else begin
            if (g >= 0) begin
               p = mq[g].pop_front();
               exp_q.push_back('{p.tag, p.value, g});
               m_valid = 1; m_tag = p.tag; m_value = p.value; m_src = g;
               rr = (g + 1) % N;
            end else begin
               m_valid = 0;
            end
            for (int i = 0; i < N; i++)
               if (src_valid[i] && rdy[i])
                  mq[i].push_back('{src_tag[i*TW +: TW], src_value[i*DW +: DW]});
         end
      end
   end

   // Monitor: compares broadcasts against the scoreboard and held outputs against the model.
   always @(negedge clk) begin
      bc_t          e;
      logic [N-1:0] exp_rdy;
      if (mon_en) begin
         for (int i = 0; i < N; i++) exp_rdy[i] = (mq[i].size() < D);
         chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
         chk("src_ready", 64'(src_ready), 64'(exp_rdy));
         if (cdb_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_broadcast", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
               chk("cdb_value", 64'(cdb_value), 64'(e.value));
               chk("cdb_src", 64'(cdb_src), 64'(e.src));
            end
         end else begin
            chk("hold_tag", 64'(cdb_tag), 64'(m_tag));
            chk("hold_value", 64'(cdb_value), 64'(m_value));
            chk("hold_src", 64'(cdb_src), 64'(m_src));
         end
      end
   end

   task automatic cyc(input bit r, input bit f, input logic [N-1:0] v,
                      input logic [N*TW-1:0] t, input logic [N*DW-1:0] d);
      rst = r; flush = f; src_valid = v; src_tag = t; src_value = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0);
   endtask

   function automatic logic [N*DW-1:0] rnd_values();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [N*TW-1:0] rnd_tags();
      return (N*TW)'($urandom);
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_value = '0;
      @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      cyc(1'b1, 1'b0, '0, '0, '0);

      // Single result from src0.
      cyc(1'b0, 1'b0, 4'b0001, 12'h003, {96'h0, 32'hDEADBEEF});
      idle(3);

      // Contention from rr_ptr=0, then src3 and src0 together.
      cyc(1'b1, 1'b0, '0, '0, '0);
      cyc(1'b0, 1'b0, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, rnd_values());
      idle(5);
      cyc(1'b0, 1'b0, 4'b1001, rnd_tags(), rnd_values());
      idle(4);

      // Backpressure: all sources valid for 20 cycles.
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 4'b1111, rnd_tags(), rnd_values());
      idle(8);

      // src1 streams tags 1,2,3 back to back.
      for (int t = 1; t <= 3; t++)
         cyc(1'b0, 1'b0, 4'b0010, (N*TW)'(t << TW), rnd_values());
      idle(4);

      // Flush while src2 handshakes tag 5.
      cyc(1'b0, 1'b0, 4'b1011, rnd_tags(), rnd_values());
      cyc(1'b0, 1'b1, 4'b0100, 12'(3'd5 << (2*TW)), rnd_values());
      idle(4);

      // Reset mid-stream with full queues, then a new result.
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b1111, rnd_tags(), rnd_values());
      cyc(1'b1, 1'b0, 4'b1111, rnd_tags(), rnd_values());
      cyc(1'b0, 1'b0, 4'b0100, rnd_tags(), rnd_values());
      idle(3);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         int unsigned k;
         k = $urandom_range(0, 99);
         cyc(k == 0, (k >= 1 && k <= 3), N'($urandom), rnd_tags(), rnd_values());
      end
      idle(12);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
